ballot_collector: RTL and testbench
===================================

# ballot_collector

Sequential front end for the four-input majority voter. It polls four voters in turn over a request/acknowledge handshake and applies a timeout so that an absent voter counts as "no". It assembles the 4-bit vote vector and hands it to the voter stage over a valid/ready handshake. The voter stage decodes that vector into the one-hot verdict: 100 for at most one yes, 010 for exactly two, 001 for three or more.

## Interface
- TIMEOUT, 8: maximum cycles one request stays asserted without acknowledge; legal range 2..255.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  begin a ballot round; sampled only in IDLE.
- req_o  output  4  one-hot request to voter idx; bit i addresses voter i.
- ack_i  input  1  addressed voter presents its ballot this cycle.
- ballot_i  input  1  ballot value qualified by ack_i; 1 = yes.
- votes_o  output  4  collected vote vector; bit i = voter i; stable while votes_valid_o is high.
- votes_valid_o  output  1  vote vector available to the voter stage.
- votes_ready_i  input  1  voter stage accepts votes_o.
- absent_o  output  4  bit i set when voter i timed out in the current or last round.
- busy_o  output  1  high in every state except IDLE.

## Operation
- States: IDLE, REQ, GAP, HOLD.
- Reset values: state IDLE, idx 0, timeout counter 0, req_o 0, votes_o 0, absent_o 0, votes_valid_o 0, busy_o 0.
- IDLE:
  - start=1 moves to REQ with idx 0, counter 0, votes_o and absent_o cleared.
  - start=0 holds IDLE; votes_o and absent_o keep the last round's values.
- REQ:
  - req_o = 1<<idx and the counter increments each cycle.
  - ack_i=1 captures votes_o[idx] = ballot_i and absent_o[idx] = 0.
  - ack_i=0 with counter == TIMEOUT-1 sets votes_o[idx] = 0 and absent_o[idx] = 1.
  - After either event: idx < 3 moves to GAP; idx == 3 moves to HOLD.
  - ack_i and timeout in the same cycle: ack_i wins.
- GAP:
  - Lasts exactly one cycle with req_o = 0.
  - Increments idx, clears the counter and returns to REQ.
  - ack_i is ignored.
- HOLD:
  - votes_valid_o = 1 and req_o = 0.
  - votes_ready_i=1 completes the transfer and returns to IDLE.
- start outside IDLE is ignored. It does not queue.
- ack_i outside REQ is ignored.
- rst_n low mid-round aborts at once: all outputs go to their reset values asynchronously and no partial vector is delivered.
- idx is 2 bits. Counter width is clog2(TIMEOUT); it never wraps because it is cleared on leaving REQ.

## Timing
- Registered outputs: req_o, votes_o, absent_o, votes_valid_o and busy_o all come from flops, with no combinational path from inputs.
- Full-speed round (ack_i high in the first REQ cycle for every voter), with start sampled at edge 0:
  - req_o active in cycles 1, 3, 5 and 7.
  - votes_valid_o high from cycle 8.
- Each timed-out voter adds TIMEOUT-1 cycles to the round.
- votes_ready_i already high on the first HOLD cycle: valid lasts one cycle and the block is back in IDLE the next cycle.
- New round: earliest start acceptance is the first IDLE cycle after the transfer.

## Structure
- Shared package ballot_pkg (shared with the voter stage) holds:
  - N_VOTERS = 4;
  - state enum {IDLE, REQ, GAP, HOLD};
  - verdict one-hot constants VERDICT_FAIL = 3'b100, VERDICT_TIE = 3'b010, VERDICT_PASS = 3'b001.
- Sub-module: one, ballot_timer, holding the clearable timeout counter with a TIMEOUT parameter and a terminal-count flag.
- Everything else stays flat in ballot_collector.

## Test plan
- Reset, then start with immediate acks and ballots 1,0,1,1; votes_ready_i tied high:
  - votes_o = 4'b1101, absent_o = 0;
  - valid in cycle 8 only;
  - downstream verdict 001.
- Voter 2 never acks, others vote yes:
  - votes_o = 4'b1011, absent_o = 4'b0100;
  - valid at cycle 8 + TIMEOUT-1.
- All four time out:
  - votes_o = 0, absent_o = 4'b1111;
  - downstream verdict 100.
- ack_i coincident with timeout cycle on voter 0 with ballot 1: votes_o[0] = 1, absent_o[0] = 0.
- votes_ready_i held low 5 cycles in HOLD, with start pulses and ack_i injected meanwhile:
  - votes_o stable and valid held for the 5 cycles;
  - no new round starts and no state change.
- rst_n pulsed low during REQ for voter 2: all outputs 0 asynchronously, state IDLE, no valid afterwards until a new start.

Source files
------------

// File: rtl/ballot_pkg.sv
// rtl/ballot_pkg.sv - shared ballot types, sizes and verdict decode for the collector and voter stage
package ballot_pkg;

    localparam int N_VOTERS = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        GAP  = 2'd2,
        HOLD = 2'd3
    } state_t;

    localparam logic [2:0] VERDICT_FAIL = 3'b100;
    localparam logic [2:0] VERDICT_TIE  = 3'b010;
    localparam logic [2:0] VERDICT_PASS = 3'b001;

    // Voter-stage decode: at most one yes fails, exactly two ties, three or more pass.
    function automatic logic [2:0] vote_verdict(input logic [N_VOTERS-1:0] votes);
        int unsigned yes_count;
        yes_count = 0;
        for (int i = 0; i < N_VOTERS; i++) begin
            yes_count = yes_count + 32'(votes[i]);
        end
        if (yes_count <= 1) begin
            return VERDICT_FAIL;
        end else if (yes_count == 2) begin
            return VERDICT_TIE;
        end
        return VERDICT_PASS;
    endfunction

endpackage

// File: rtl/ballot_collector_if.sv
// rtl/ballot_collector_if.sv - voter polling and vote-vector handshake signals
interface ballot_collector_if;
    import ballot_pkg::*;

    logic                start;
    logic [N_VOTERS-1:0] req_o;
    logic                ack_i;
    logic                ballot_i;
    logic [N_VOTERS-1:0] votes_o;
    logic                votes_valid_o;
    logic                votes_ready_i;
    logic [N_VOTERS-1:0] absent_o;
    logic                busy_o;

    modport master (
        input  start,
        input  ack_i,
        input  ballot_i,
        input  votes_ready_i,
        output req_o,
        output votes_o,
        output votes_valid_o,
        output absent_o,
        output busy_o
    );

    modport slave (
        output start,
        output ack_i,
        output ballot_i,
        output votes_ready_i,
        input  req_o,
        input  votes_o,
        input  votes_valid_o,
        input  absent_o,
        input  busy_o
    );

endinterface

// File: rtl/ballot_timer.sv
// rtl/ballot_timer.sv - clearable per-request timeout counter with terminal-count flag
module ballot_timer #(
    parameter int TIMEOUT = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic inc,
    output logic tc
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [CW-1:0] cnt;

    assign tc = (cnt == CW'(TIMEOUT - 1));

    // Holding at terminal count keeps the counter from wrapping even if clr arrives late.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && !tc) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/ballot_collector.sv
// rtl/ballot_collector.sv - polls four voters with timeout and hands the vote vector to the voter stage
module ballot_collector
    import ballot_pkg::*;
#(
    parameter int TIMEOUT = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    ballot_collector_if.master  bus
);

    state_t              state, state_n;
    logic [1:0]          idx, idx_n;
    logic [N_VOTERS-1:0] votes_q, votes_n;
    logic [N_VOTERS-1:0] absent_q, absent_n;
    logic [N_VOTERS-1:0] req_q;
    logic                valid_q;
    logic                busy_q;
    logic                timer_tc;
    logic                settled;

    ballot_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (state_n != REQ),
        .inc   (state == REQ),
        .tc    (timer_tc)
    );

    always_comb begin
        state_n  = state;
        idx_n    = idx;
        votes_n  = votes_q;
        absent_n = absent_q;
        settled  = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_n  = REQ;
                    idx_n    = 2'd0;
                    votes_n  = '0;
                    absent_n = '0;
                end
            end
            REQ: begin
                // A late ack on the terminal cycle still counts as a real ballot.
                if (bus.ack_i) begin
                    votes_n[idx]  = bus.ballot_i;
                    absent_n[idx] = 1'b0;
                    settled       = 1'b1;
                end else if (timer_tc) begin
                    votes_n[idx]  = 1'b0;
                    absent_n[idx] = 1'b1;
                    settled       = 1'b1;
                end
                if (settled) begin
                    state_n = (idx == 2'(N_VOTERS - 1)) ? HOLD : GAP;
                end
            end
            GAP: begin
                idx_n   = idx + 2'd1;
                state_n = REQ;
            end
            HOLD: begin
                if (bus.votes_ready_i) begin
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Outputs are registered from the next-state values so they line up with the state they describe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            idx      <= 2'd0;
            votes_q  <= '0;
            absent_q <= '0;
            req_q    <= '0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state    <= state_n;
            idx      <= idx_n;
            votes_q  <= votes_n;
            absent_q <= absent_n;
            req_q    <= (state_n == REQ) ? (N_VOTERS'(1) << idx_n) : '0;
            valid_q  <= (state_n == HOLD);
            busy_q   <= (state_n != IDLE);
        end
    end

    assign bus.req_o         = req_q;
    assign bus.votes_o       = votes_q;
    assign bus.absent_o      = absent_q;
    assign bus.votes_valid_o = valid_q;
    assign bus.busy_o        = busy_q;

endmodule

// File: tb/tb_ballot_collector.sv
// tb/tb_ballot_collector.sv - randomized cycle-planned bench for ballot_collector
module tb_ballot_collector;
    import ballot_pkg::*;

    localparam int T     = 8;
    localparam int MAXC  = 4096;
    localparam int NEVER = 255;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    ballot_collector_if bus ();

    ballot_collector #(
        .TIMEOUT (T)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    bit         in_start  [MAXC];
    bit         in_ack    [MAXC];
    bit         in_ballot [MAXC];
    bit         in_ready  [MAXC];
    bit         in_rstn   [MAXC];
    logic [3:0] e_req     [MAXC];
    logic [3:0] e_votes   [MAXC];
    logic [3:0] e_absent  [MAXC];
    bit         e_valid   [MAXC];
    bit         e_busy    [MAXC];
    bit         lit_on    [MAXC];
    logic [3:0] lit_votes [MAXC];
    logic [3:0] lit_absent[MAXC];
    logic [2:0] lit_verd  [MAXC];

    int         p;
    logic [3:0] m_votes;
    logic [3:0] m_absent;
    int         pd [4];
    bit         pb [4];
    int         p_abort;
    int         total = 0;
    int         bad = 0;
    int         cyc = 0;
    bit         active = 1'b0;

    function automatic bit rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic [2:0] model_verdict(input logic [3:0] v);
        int n;
        n = $countones(v);
        if (n <= 1) return 3'b100;
        if (n == 2) return 3'b010;
        return 3'b001;
    endfunction

    task automatic chk(input string name, input int k, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cycle=%0d got=%0h want=%0h", name, k, act, exp);
        end
    endtask

    task automatic put(input bit st, input bit ak, input bit bl, input bit rd, input bit rn,
                       input logic [3:0] rq, input bit vl, input bit bs);
        in_start[p]  = st;
        in_ack[p]    = ak;
        in_ballot[p] = bl;
        in_ready[p]  = rd;
        in_rstn[p]   = rn;
        e_req[p]     = rq;
        e_valid[p]   = vl;
        e_busy[p]    = bs;
        e_votes[p]   = m_votes;
        e_absent[p]  = m_absent;
        p++;
    endtask

    task automatic plan_idle(input int n);
        repeat (n) put(1'b0, rb(), rb(), rb(), 1'b1, 4'b0, 1'b0, 1'b0);
    endtask

    task automatic pin(input int h, input logic [3:0] v, input logic [3:0] a, input logic [2:0] vd);
        lit_on[h]     = 1'b1;
        lit_votes[h]  = v;
        lit_absent[h] = a;
        lit_verd[h]   = vd;
    endtask

    // One ballot round from the start cycle through HOLD; each voter's REQ lasts until its ack or TIMEOUT cycles.
    task automatic plan_round(input int w, output int c, output int h);
        int r;
        bit ak;
        c = p;
        h = -1;
        put(1'b1, rb(), rb(), rb(), 1'b1, 4'b0, 1'b0, 1'b0);
        m_votes  = 4'b0;
        m_absent = 4'b0;
        for (int i = 0; i < 4; i++) begin
            r = (pd[i] < T) ? pd[i] + 1 : T;
            for (int j = 0; j < r; j++) begin
                if (i == p_abort && j == 1) begin
                    m_votes  = 4'b0;
                    m_absent = 4'b0;
                    put(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0, 1'b0, 1'b0);
                    return;
                end
                ak = (pd[i] < T) && (j == pd[i]);
                put(rb(), ak, ak ? pb[i] : rb(), rb(), 1'b1, 4'(1 << i), 1'b0, 1'b1);
            end
            m_votes[i]  = (pd[i] < T) ? pb[i] : 1'b0;
            m_absent[i] = (pd[i] >= T);
            if (i < 3) put(rb(), rb(), rb(), rb(), 1'b1, 4'b0, 1'b0, 1'b1);
        end
        h = p;
        for (int k = 0; k <= w; k++) put(rb(), rb(), rb(), (k == w), 1'b1, 4'b0, 1'b1, 1'b1);
    endtask

    task automatic set_voters(input int d0, input int d1, input int d2, input int d3,
                              input bit b0, input bit b1, input bit b2, input bit b3);
        pd[0] = d0; pd[1] = d1; pd[2] = d2; pd[3] = d3;
        pb[0] = b0; pb[1] = b1; pb[2] = b2; pb[3] = b3;
    endtask

    always @(negedge clk) begin
        if (active) begin
            chk("req", cyc, 8'(bus.req_o), 8'(e_req[cyc]));
            chk("valid", cyc, 8'(bus.votes_valid_o), 8'(e_valid[cyc]));
            chk("busy", cyc, 8'(bus.busy_o), 8'(e_busy[cyc]));
            chk("votes", cyc, 8'(bus.votes_o), 8'(e_votes[cyc]));
            chk("absent", cyc, 8'(bus.absent_o), 8'(e_absent[cyc]));
            if (e_valid[cyc]) chk("verdict", cyc, 8'(vote_verdict(bus.votes_o)), 8'(model_verdict(e_votes[cyc])));
            if (lit_on[cyc]) begin
                chk("lit_votes", cyc, 8'(bus.votes_o), 8'(lit_votes[cyc]));
                chk("lit_absent", cyc, 8'(bus.absent_o), 8'(lit_absent[cyc]));
                chk("lit_verdict", cyc, 8'(vote_verdict(bus.votes_o)), 8'(lit_verd[cyc]));
            end
        end
    end

    initial begin
        int c, h;
        bus.start = 1'b0;
        bus.ack_i = 1'b0;
        bus.ballot_i = 1'b0;
        bus.votes_ready_i = 1'b0;
        p = 0;
        p_abort = -1;
        m_votes = 4'b0;
        m_absent = 4'b0;

        repeat (3) put(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0, 1'b0, 1'b0);
        plan_idle(2);

        set_voters(0, 0, 0, 0, 1'b1, 1'b0, 1'b1, 1'b1);
        plan_round(0, c, h);
        pin(h, 4'b1101, 4'b0000, 3'b001);
        chk("model_fullspeed_latency", c, 8'(h - c), 8'd8);
        plan_idle(2);

        set_voters(0, 0, NEVER, 0, 1'b1, 1'b1, 1'b1, 1'b1);
        plan_round(0, c, h);
        pin(h, 4'b1011, 4'b0100, 3'b001);
        chk("model_timeout_latency", c, 8'(h - c), 8'(8 + T - 1));
        plan_idle(1);

        set_voters(NEVER, NEVER, NEVER, NEVER, 1'b1, 1'b1, 1'b1, 1'b1);
        plan_round(0, c, h);
        pin(h, 4'b0000, 4'b1111, 3'b100);
        plan_idle(0);

        set_voters(T - 1, 0, 0, 0, 1'b1, 1'b0, 1'b0, 1'b0);
        plan_round(0, c, h);
        pin(h, 4'b0001, 4'b0000, 3'b100);
        plan_idle(1);

        set_voters(0, 2, NEVER, 1, 1'b0, 1'b1, 1'b0, 1'b1);
        plan_round(5, c, h);
        for (int k = h; k <= h + 5; k++) begin
            in_start[k] = 1'b1;
            in_ack[k]   = 1'b1;
            pin(k, 4'b1010, 4'b0100, 3'b010);
        end
        plan_idle(2);

        set_voters(0, 0, NEVER, 0, 1'b1, 1'b1, 1'b1, 1'b1);
        p_abort = 2;
        plan_round(0, c, h);
        p_abort = -1;
        plan_idle(4);

        for (int n = 0; n < 30; n++) begin
            for (int i = 0; i < 4; i++) begin
                pd[i] = ($urandom_range(0, 3) == 0) ? NEVER : int'($urandom_range(0, T - 1));
                pb[i] = rb();
            end
            plan_round(int'($urandom_range(0, 3)), c, h);
            plan_idle(int'($urandom_range(0, 2)));
        end

        for (int k = 0; k < p; k++) begin
            @(posedge clk);
            #1;
            cyc = k;
            active = 1'b1;
            rst_n = in_rstn[k];
            bus.start = in_start[k];
            bus.ack_i = in_ack[k];
            bus.ballot_i = in_ballot[k];
            bus.votes_ready_i = in_ready[k];
        end
        @(posedge clk);
        active = 1'b0;
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
